// File: rtl/sayeh_page_mem_ctrl.sv
// Paged memory controller for the SAYEH CPU memory port.
// One page is held in a local buffer. CPU reads and writes are served from
// that buffer. On a page miss the resident page is written back if it is
// dirty, and then the requested page is filled from the word-wide backing
// store.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for a CPU request or a flush pulse
// S_WB    | writing the dirty resident page back, one word per bs_ack
// S_FILL  | reading the requested page into the buffer, one word per bs_ack
// S_SERVE | one cycle: apply the write, or register the read word
// S_DONE  | MemDataready high until the CPU drops ReadMem and WriteMem
module sayeh_page_mem_ctrl #(
   parameter int ADDR_W = 16,
   parameter int PAGE_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              ExternalReset,
   input  logic              ReadMem,
   input  logic              WriteMem,
   input  logic [ADDR_W-1:0] Addressbus,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              MemDataready,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              busy,
   output logic              bs_req,
   output logic              bs_we,
   output logic [ADDR_W-1:0] bs_addr,
   output logic [DATA_W-1:0] bs_wdata,
   input  logic [DATA_W-1:0] bs_rdata,
   input  logic              bs_ack
);

   localparam int OFFS_W = ADDR_W - PAGE_W;
   localparam int DEPTH  = 1 << OFFS_W;
   localparam logic [OFFS_W-1:0] CNT_ONE = OFFS_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_SERVE, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_buf [DEPTH];
   logic [OFFS_W-1:0]   r_cnt;
   logic [PAGE_W-1:0]   r_res_page;
   logic                r_valid;
   logic                r_dirty;
   logic                r_flushing;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_wr;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_flush_done;

   logic                w_req;
   logic                w_hit;
   logic                w_last;
   logic [PAGE_W-1:0]   w_new_page;
   logic [OFFS_W-1:0]   w_offs;

   assign w_req      = ReadMem | WriteMem;
   assign w_hit      = r_valid && (Addressbus[ADDR_W-1:OFFS_W] == r_res_page);
   assign w_last     = (r_cnt == {OFFS_W{1'b1}});
   assign w_new_page = r_addr[ADDR_W-1:OFFS_W];
   assign w_offs     = r_addr[OFFS_W-1:0];

   // State register; a reset aborts any transfer in progress.
   always_ff @(posedge clk or negedge ExternalReset) begin
      if (!ExternalReset) r_state <= S_IDLE;
      else                r_state <= w_next;
   end

   // Next-state decode. A CPU request takes precedence over a flush pulse.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_hit)                  w_next = S_SERVE;
               else if (r_valid && r_dirty) w_next = S_WB;
               else                        w_next = S_FILL;
            end else if (flush_req && r_valid && r_dirty) begin
               w_next = S_WB;
            end
         end
         S_WB:    if (bs_ack && w_last) w_next = r_flushing ? S_IDLE : S_FILL;
         S_FILL:  if (bs_ack && w_last) w_next = S_SERVE;
         S_SERVE: w_next = S_DONE;
         S_DONE:  if (!w_req) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Control and datapath registers: request latch, page tags, beat counter.
   always_ff @(posedge clk or negedge ExternalReset) begin
      if (!ExternalReset) begin
         r_cnt        <= '0;
         r_res_page   <= '0;
         r_valid      <= 1'b0;
         r_dirty      <= 1'b0;
         r_flushing   <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wr         <= 1'b0;
         r_rdata      <= '0;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_addr     <= Addressbus;
                  r_wdata    <= cpu_wdata;
                  r_wr       <= WriteMem;
                  r_flushing <= 1'b0;
               end else if (flush_req) begin
                  if (r_valid && r_dirty) r_flushing   <= 1'b1;
                  else                    r_flush_done <= 1'b1;
               end
            end
            S_WB: begin
               if (bs_ack) begin
                  r_cnt <= r_cnt + CNT_ONE;
                  if (w_last) begin
                     r_dirty <= 1'b0;
                     if (r_flushing) begin
                        r_flush_done <= 1'b1;
                        r_flushing   <= 1'b0;
                     end
                  end
               end
            end
            S_FILL: begin
               if (bs_ack) begin
                  r_cnt <= r_cnt + CNT_ONE;
                  if (w_last) begin
                     r_res_page <= w_new_page;
                     r_valid    <= 1'b1;
                     r_dirty    <= 1'b0;
                  end
               end
            end
            S_SERVE: begin
               if (r_wr) r_dirty <= 1'b1;
               else      r_rdata <= r_buf[w_offs];
            end
            default: ;
         endcase
      end
   end

   // Page buffer: fill beats from the store, single CPU write in SERVE.
   always_ff @(posedge clk) begin
      if (r_state == S_FILL && bs_ack) r_buf[r_cnt]  <= bs_rdata;
      else if (r_state == S_SERVE && r_wr) r_buf[w_offs] <= r_wdata;
   end

   // Output decode from the current state.
   always_comb begin
      bs_req       = 1'b0;
      bs_we        = 1'b0;
      bs_addr      = '0;
      bs_wdata     = '0;
      MemDataready = 1'b0;
      busy         = (r_state != S_IDLE);
      case (r_state)
         S_WB: begin
            bs_req   = 1'b1;
            bs_we    = 1'b1;
            bs_addr  = {r_res_page, r_cnt};
            bs_wdata = r_buf[r_cnt];
         end
         S_FILL: begin
            bs_req  = 1'b1;
            bs_addr = {w_new_page, r_cnt};
         end
         S_DONE:  MemDataready = 1'b1;
         default: ;
      endcase
   end

   assign cpu_rdata  = r_rdata;
   assign flush_done = r_flush_done;

endmodule

// File: tb/tb_sayeh_page_mem_ctrl.sv
// Bench for sayeh_page_mem_ctrl with 16-word pages (PAGE_W=12).
// The CPU sees a flat memory (ref_mem). The backing store model acks every
// ack_div-th cycle of a request and logs each transfer.
module tb_sayeh_page_mem_ctrl;
   localparam int AW = 16;
   localparam int PW = 12;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          ExternalReset = 1'b0;
   logic          ReadMem = 1'b0;
   logic          WriteMem = 1'b0;
   logic [AW-1:0] Addressbus = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          MemDataready;
   logic          flush_req = 1'b0;
   logic          flush_done;
   logic          busy;
   logic          bs_req;
   logic          bs_we;
   logic [AW-1:0] bs_addr;
   logic [DW-1:0] bs_wdata;
   logic [DW-1:0] bs_rdata = '0;
   logic          bs_ack = 1'b0;

   sayeh_page_mem_ctrl #(.ADDR_W(AW), .PAGE_W(PW), .DATA_W(DW)) dut (
      .clk(clk), .ExternalReset(ExternalReset), .ReadMem(ReadMem), .WriteMem(WriteMem),
      .Addressbus(Addressbus), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .MemDataready(MemDataready), .flush_req(flush_req), .flush_done(flush_done),
      .busy(busy), .bs_req(bs_req), .bs_we(bs_we), .bs_addr(bs_addr),
      .bs_wdata(bs_wdata), .bs_rdata(bs_rdata), .bs_ack(bs_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        we;
      logic [15:0] addr;
      logic [15:0] data;
   } xfer_t;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          hold;
      logic [15:0] exp_rdata;
      int          exp_lat;
      int          exp_nrd;
      logic [15:0] rd_base;
      int          exp_nwr;
      logic [15:0] wr_base;
   } vec_t;

   logic [15:0] store_mem [65536];
   logic [15:0] ref_mem   [65536];
   xfer_t       log_q[$];
   int          ack_div = 1;
   int          ack_wait = 0;
   int          total = 0;
   int          bad = 0;

   // Backing store: decides the ack for the coming edge and logs the beat.
   always @(negedge clk) begin
      if (bs_req && ExternalReset) begin
         if (ack_wait >= ack_div - 1) begin
            bs_ack   = 1'b1;
            ack_wait = 0;
            if (bs_we) begin
               store_mem[bs_addr] = bs_wdata;
               log_q.push_back('{1'b1, bs_addr, bs_wdata});
            end else begin
               bs_rdata = store_mem[bs_addr];
               log_q.push_back('{1'b0, bs_addr, store_mem[bs_addr]});
            end
         end else begin
            bs_ack   = 1'b0;
            ack_wait = ack_wait + 1;
         end
      end else begin
         bs_ack   = 1'b0;
         ack_wait = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int n_reads();
      int n = 0;
      foreach (log_q[i]) if (!log_q[i].we) n++;
      return n;
   endfunction

   // Store traffic of the last operation: counts, address order, write-back data.
   task automatic check_log(input string tag, input int exp_nrd, input logic [15:0] rd_base,
                            input int exp_nwr, input logic [15:0] wr_base);
      int nr = 0;
      int nw = 0;
      int seq_bad = 0;
      int dat_bad = 0;
      foreach (log_q[i]) begin
         if (log_q[i].we) begin
            if (nr > 0) seq_bad++;
            if (log_q[i].addr !== wr_base + 16'(nw)) seq_bad++;
            if (log_q[i].data !== ref_mem[log_q[i].addr]) dat_bad++;
            nw++;
         end else begin
            if (log_q[i].addr !== rd_base + 16'(nr)) seq_bad++;
            nr++;
         end
      end
      check({tag, " n_fill"}, nr, exp_nrd);
      check({tag, " n_wb"}, nw, exp_nwr);
      check({tag, " bs_addr_order"}, seq_bad, 0);
      check({tag, " wb_data"}, dat_bad, 0);
   endtask

   // One CPU access. hold = extra cycles the request stays up after MemDataready,
   // during which the address and data buses are scrambled.
   task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int hold, input string tag,
                         output logic [15:0] rdata, output int lat, output int mdr_hi);
      @(negedge clk);
      log_q.delete();
      ReadMem    = rd;
      WriteMem   = wr;
      Addressbus = addr;
      cpu_wdata  = wdata;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!MemDataready && lat < 400);
      if (!MemDataready) check({tag, " timeout"}, 1, 0);
      rdata  = cpu_rdata;
      mdr_hi = MemDataready ? 1 : 0;
      for (int i = 0; i < hold; i++) begin
         Addressbus = addr ^ 16'h0002;
         cpu_wdata  = ~wdata;
         @(negedge clk);
         if (MemDataready && cpu_rdata === rdata) mdr_hi++;
      end
      ReadMem  = 1'b0;
      WriteMem = 1'b0;
      @(negedge clk);
      check({tag, " mdr_drop"}, MemDataready, 0);
      check({tag, " idle_after"}, busy, 0);
   endtask

   // Single flush pulse, observed over a fixed window.
   task automatic flush_pulse(output int ndone, output bit first_done, output int maxlen);
      @(negedge clk);
      log_q.delete();
      flush_req = 1'b1;
      @(negedge clk);
      flush_req  = 1'b0;
      first_done = flush_done;
      ndone      = flush_done ? 1 : 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (flush_done) ndone++;
      end
      maxlen = busy ? 1 : 0;
   endtask

   initial begin
      vec_t        vecs[8];
      logic [15:0] rdata;
      int          lat;
      int          mdr_hi;
      int          ndone;
      bit          first_done;
      int          still_busy;
      int          k;
      logic [11:0] res_m;
      bit          dirty_m;
      logic [11:0] pages[4];
      int          nmis;

      for (int a = 0; a < 65536; a++) begin
         store_mem[a] = 16'(a) ^ 16'h5A5A;
      end
      for (int o = 0; o < 16; o++) store_mem[16'h0120 + o] = 16'hA000 + 16'(o);
      for (int a = 0; a < 65536; a++) ref_mem[a] = store_mem[a];

      //          rd  wr  addr      wdata     hold exp_rd    lat nrd rd_base   nwr wr_base
      vecs[0] = '{1, 0, 16'h0123, 16'h0000, 0, 16'hA003, -1, 16, 16'h0120, 0,  16'h0000};
      vecs[1] = '{0, 1, 16'h0125, 16'hBEEF, 0, 16'h0000,  2, 0,  16'h0000, 0,  16'h0000};
      vecs[2] = '{1, 0, 16'h0125, 16'h0000, 0, 16'hBEEF,  2, 0,  16'h0000, 0,  16'h0000};
      vecs[3] = '{1, 0, 16'h0457, 16'h0000, 0, 16'h5E0D, -1, 16, 16'h0450, 16, 16'h0120};
      vecs[4] = '{1, 1, 16'h0121, 16'h5555, 5, 16'h0000, -1, 16, 16'h0120, 0,  16'h0000};
      vecs[5] = '{1, 0, 16'h0121, 16'h0000, 0, 16'h5555,  2, 0,  16'h0000, 0,  16'h0000};
      vecs[6] = '{1, 0, 16'h0125, 16'h0000, 0, 16'hBEEF,  2, 0,  16'h0000, 0,  16'h0000};
      vecs[7] = '{1, 0, 16'h0123, 16'h0000, 0, 16'hA003,  2, 0,  16'h0000, 0,  16'h0000};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst MemDataready", MemDataready, 0);
      check("rst cpu_rdata", cpu_rdata, 0);
      check("rst bs_req", bs_req, 0);
      check("rst bs_we", bs_we, 0);
      check("rst bs_addr", bs_addr, 0);
      check("rst bs_wdata", bs_wdata, 0);
      check("rst flush_done", flush_done, 0);
      check("rst busy", busy, 0);
      ExternalReset = 1'b1;

      // Table vectors: read miss, write hit, dirty miss, combined request.
      for (int v = 0; v < 8; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         access(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].hold, tag,
                rdata, lat, mdr_hi);
         if (vecs[v].rd && !vecs[v].wr) check({tag, " rdata"}, rdata, vecs[v].exp_rdata);
         if (vecs[v].exp_lat > 0) check({tag, " latency"}, lat, vecs[v].exp_lat);
         if (vecs[v].hold > 0) check({tag, " mdr_held"}, mdr_hi, vecs[v].hold + 1);
         check_log(tag, vecs[v].exp_nrd, vecs[v].rd_base, vecs[v].exp_nwr, vecs[v].wr_base);
         if (vecs[v].wr) ref_mem[vecs[v].addr] = vecs[v].wdata;
      end

      // Flush of a dirty page, then a flush of the now clean page.
      flush_pulse(ndone, first_done, still_busy);
      check("flush1 done_pulses", ndone, 1);
      check("flush1 busy_after", still_busy, 0);
      check_log("flush1", 0, 16'h0000, 16, 16'h0120);
      check("flush1 store_0125", store_mem[16'h0125], 16'hBEEF);
      flush_pulse(ndone, first_done, still_busy);
      check("flush2 done_next_cycle", first_done, 1);
      check("flush2 done_pulses", ndone, 1);
      check("flush2 no_traffic", log_q.size(), 0);

      // Reset in the middle of a slow fill.
      ack_div = 3;
      @(negedge clk);
      log_q.delete();
      ReadMem    = 1'b1;
      Addressbus = 16'h0789;
      k = 0;
      while (n_reads() < 7 && k < 300) begin
         @(negedge clk);
         #2;
         k++;
      end
      check("rst_mid reached_beat7", (k < 300) ? 1 : 0, 1);
      check("rst_mid in_fill", bs_req, 1);
      ExternalReset = 1'b0;
      ReadMem       = 1'b0;
      #1;
      check("rst_mid bs_req", bs_req, 0);
      check("rst_mid busy", busy, 0);
      check("rst_mid MemDataready", MemDataready, 0);
      @(negedge clk);
      @(negedge clk);
      ExternalReset = 1'b1;
      ack_div = 1;
      access(1, 0, 16'h0789, 16'h0000, 0, "refill", rdata, lat, mdr_hi);
      check("refill rdata", rdata, ref_mem[16'h0789]);
      check_log("refill", 16, 16'h0780, 0, 16'h0000);

      // Random traffic against the flat-memory view.
      pages   = '{12'h012, 12'h045, 12'h078, 12'h0AB};
      res_m   = 12'h078;
      dirty_m = 1'b0;
      for (int n = 0; n < 40; n++) begin
         logic [15:0] addr;
         logic [15:0] wd;
         int          op;
         int          hold;
         int          exp_nrd;
         int          exp_nwr;
         logic [15:0] wb_base;
         bit          hit;
         string       tag;
         tag     = $sformatf("rnd%0d", n);
         addr    = {pages[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
         wd      = 16'($urandom);
         op      = $urandom_range(0, 2);
         hold    = $urandom_range(0, 2);
         ack_div = $urandom_range(1, 3);
         hit     = (addr[15:4] == res_m);
         exp_nrd = hit ? 0 : 16;
         exp_nwr = (!hit && dirty_m) ? 16 : 0;
         wb_base = {res_m, 4'h0};
         access(op == 0, op != 0, addr, wd, hold, tag, rdata, lat, mdr_hi);
         if (op == 0) check({tag, " rdata"}, rdata, ref_mem[addr]);
         if (hit) check({tag, " hit_latency"}, lat, 2);
         check_log(tag, exp_nrd, {addr[15:4], 4'h0}, exp_nwr, wb_base);
         if (!hit) begin
            res_m   = addr[15:4];
            dirty_m = 1'b0;
         end
         if (op != 0) begin
            ref_mem[addr] = wd;
            dirty_m = 1'b1;
         end
      end

      // Final flush: the store must then match the flat view everywhere touched.
      ack_div = 1;
      flush_pulse(ndone, first_done, still_busy);
      check("final_flush done_pulses", ndone, 1);
      nmis = 0;
      for (int p = 0; p < 4; p++) begin
         for (int o = 0; o < 16; o++) begin
            if (store_mem[{pages[p], 4'(o)}] !== ref_mem[{pages[p], 4'(o)}]) nmis++;
         end
      end
      for (int o = 0; o < 16; o++) begin
         if (store_mem[16'h0450 + o] !== ref_mem[16'h0450 + o]) nmis++;
      end
      check("final coherence_mismatches", nmis, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
